// File: rtl/nco_ctrl_pkg.sv
// Shared types and constants for the NCO frequency-sweep sequencer.
// Holds the FSM states, config register map, control bit positions and reset values.
package nco_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WR_LO = 2'd1,
        WR_HI = 2'd2,
        DWELL = 2'd3
    } sweepState_t;

    localparam logic [2:0] CFG_START_LO = 3'd0;
    localparam logic [2:0] CFG_START_HI = 3'd1;
    localparam logic [2:0] CFG_STOP_LO  = 3'd2;
    localparam logic [2:0] CFG_STOP_HI  = 3'd3;
    localparam logic [2:0] CFG_STEP_LO  = 3'd4;
    localparam logic [2:0] CFG_STEP_HI  = 3'd5;
    localparam logic [2:0] CFG_DWELL    = 3'd6;
    localparam logic [2:0] CFG_CTRL     = 3'd7;

    localparam int CTRL_MODE_LSB = 0;
    localparam int CTRL_DIR      = 2;
    localparam int CTRL_LOOP     = 3;

    localparam int NCO_LOAD_LO = 2;
    localparam int NCO_LOAD_HI = 3;

    localparam logic [15:0] RST_START_FCW = 16'h0008;
    localparam logic [15:0] RST_STOP_FCW  = 16'h0008;
    localparam logic [15:0] RST_STEP      = 16'h0001;
    localparam logic [7:0]  RST_DWELL     = 8'h00;
    localparam logic [7:0]  RST_CTRL      = 8'h00;

    function automatic logic [7:0] cfgResetValue(input logic [2:0] addr);
        case (addr)
            CFG_START_LO: cfgResetValue = RST_START_FCW[7:0];
            CFG_START_HI: cfgResetValue = RST_START_FCW[15:8];
            CFG_STOP_LO:  cfgResetValue = RST_STOP_FCW[7:0];
            CFG_STOP_HI:  cfgResetValue = RST_STOP_FCW[15:8];
            CFG_STEP_LO:  cfgResetValue = RST_STEP[7:0];
            CFG_STEP_HI:  cfgResetValue = RST_STEP[15:8];
            CFG_DWELL:    cfgResetValue = RST_DWELL;
            default:      cfgResetValue = RST_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/nco_sweep_cfg_regs.sv
// Eight byte-wide host config registers with address decode.
// cfgView shows a write in flight so a start in the same cycle captures it.
module nco_sweep_cfg_regs
    import nco_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cfgValid,
    input  logic [2:0]  cfgAddr,
    input  logic [7:0]  cfgData,
    output logic [63:0] cfgView
);

    for (genvar gi = 0; gi < 8; gi++) begin : gReg
        logic [7:0] q;
        logic       wrHit;

        assign wrHit = cfgValid && (cfgAddr == 3'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q <= cfgResetValue(3'(gi));
            end else if (wrHit) begin
                q <= cfgData;
            end
        end

        assign cfgView[gi*8 +: 8] = wrHit ? cfgData : q;
    end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer: loads each FCW into the NCO as lo/hi byte writes,
// dwells for dwell+1 enabled samples, then steps toward stop, loops or finishes.
module nco_sweep_ctrl
    import nco_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       cfgValid,
    input  logic [2:0] cfgAddr,
    input  logic [7:0] cfgData,
    input  logic       start,
    input  logic       abort,
    output logic [7:0] ncoDataIn,
    output logic [7:0] ncoCtrlIn,
    output logic       busy,
    output logic       done
);

    logic [63:0] cfgView;
    logic        unusedCtrlBits;

    nco_sweep_cfg_regs uCfgRegs (
        .clk      (clk),
        .rst_n    (rst_n),
        .cfgValid (cfgValid),
        .cfgAddr  (cfgAddr),
        .cfgData  (cfgData),
        .cfgView  (cfgView)
    );

    assign unusedCtrlBits = ^cfgView[63:60];

    sweepState_t stateReg, stateNext;
    logic [15:0] curReg, curNext;
    logic [7:0]  dwellCntReg, dwellCntNext;
    logic        doneReg, doneNext;
    logic        capture;

    // Working copies so host writes during a sweep only affect the next start
    logic [15:0] startWReg, stopWReg, stepWReg;
    logic [7:0]  dwellWReg;
    logic        dirReg, loopReg;
    logic [1:0]  modeReg;

    logic [16:0] upSum, dnDiff, nextFcw;
    logic        finish;

    assign upSum   = {1'b0, curReg} + {1'b0, stepWReg};
    assign dnDiff  = {1'b0, curReg} - {1'b0, stepWReg};
    assign nextFcw = dirReg ? dnDiff : upSum;
    assign finish  = (stepWReg == 16'h0000) ||
                     (dirReg ? (dnDiff[16] || (dnDiff[15:0] < stopWReg))
                             : (upSum[16]  || (upSum[15:0]  > stopWReg)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            curReg      <= 16'h0000;
            dwellCntReg <= 8'h00;
            doneReg     <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            curReg      <= curNext;
            dwellCntReg <= dwellCntNext;
            doneReg     <= doneNext;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            startWReg <= RST_START_FCW;
            stopWReg  <= RST_STOP_FCW;
            stepWReg  <= RST_STEP;
            dwellWReg <= RST_DWELL;
            dirReg    <= 1'b0;
            loopReg   <= 1'b0;
            modeReg   <= 2'b00;
        end else if (capture) begin
            startWReg <= cfgView[15:0];
            stopWReg  <= cfgView[31:16];
            stepWReg  <= cfgView[47:32];
            dwellWReg <= cfgView[55:48];
            dirReg    <= cfgView[56 + CTRL_DIR];
            loopReg   <= cfgView[56 + CTRL_LOOP];
            modeReg   <= cfgView[56 + CTRL_MODE_LSB +: 2];
        end
    end

    always_comb begin
        stateNext    = stateReg;
        curNext      = curReg;
        dwellCntNext = dwellCntReg;
        doneNext     = 1'b0;
        capture      = 1'b0;
        if (abort) begin
            stateNext = IDLE;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (start) begin
                        capture   = 1'b1;
                        curNext   = cfgView[15:0];
                        stateNext = WR_LO;
                    end
                end
                WR_LO: begin
                    if (enable) stateNext = WR_HI;
                end
                WR_HI: begin
                    if (enable) begin
                        dwellCntNext = dwellWReg;
                        stateNext    = DWELL;
                    end
                end
                DWELL: begin
                    if (enable) begin
                        if (dwellCntReg != 8'h00) begin
                            dwellCntNext = dwellCntReg - 8'h01;
                        end else if (!finish) begin
                            curNext   = nextFcw[15:0];
                            stateNext = WR_LO;
                        end else if (loopReg) begin
                            curNext   = startWReg;
                            stateNext = WR_LO;
                        end else begin
                            stateNext = IDLE;
                            doneNext  = 1'b1;
                        end
                    end
                end
                default: stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        ncoDataIn = 8'h00;
        ncoCtrlIn = 8'h00;
        case (stateReg)
            WR_LO: begin
                ncoDataIn              = curReg[7:0];
                ncoCtrlIn              = {6'b0, modeReg};
                ncoCtrlIn[NCO_LOAD_LO] = 1'b1;
            end
            WR_HI: begin
                ncoDataIn              = curReg[15:8];
                ncoCtrlIn              = {6'b0, modeReg};
                ncoCtrlIn[NCO_LOAD_HI] = 1'b1;
            end
            DWELL:   ncoCtrlIn = {6'b0, modeReg};
            default: ;
        endcase
    end

    assign busy = (stateReg != IDLE);
    assign done = doneReg;

endmodule
